// File: rtl/dynvc_buffer_ctrl.sv
// Write admission, per-VC occupancy and read arbitration for one dynamic-VC bank.
// Optional build macro DYNVC_OVERFLOW_CHECK_EN: sticky error_overflow on refused flits.
module dynvc_buffer_ctrl #(
  parameter int num_vcs         = 10,
  parameter int buffer_depth    = 32,
  parameter int reserved_per_vc = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [num_vcs-1:0] in_vc,
  output logic               in_accept,
  output logic               write_enable,
  output logic [num_vcs-1:0] vc_written_into,
  input  logic [num_vcs-1:0] rd_req,
  output logic               read_enable,
  output logic [num_vcs-1:0] vc_read_from,
  output logic [num_vcs-1:0] rd_grant,
  input  logic               bank_full,
  output logic               credit_valid,
  output logic [num_vcs-1:0] credit_vc,
  output logic [num_vcs-1:0] vc_empty,
  output logic               error_overflow
);

  localparam int cnt_width = $clog2(buffer_depth + 1);
  localparam int RRW       = (num_vcs > 1) ? $clog2(num_vcs) : 1;
  localparam int SHARED    = buffer_depth - num_vcs * reserved_per_vc;

  localparam logic [cnt_width-1:0] RES_C  = cnt_width'(reserved_per_vc);
  localparam logic [cnt_width-1:0] SHR_C  = cnt_width'(SHARED);
  localparam logic [cnt_width-1:0] DEP_C  = cnt_width'(buffer_depth);
  localparam logic [RRW:0]         NV_C   = (RRW + 1)'(num_vcs);
  localparam logic [RRW-1:0]       LAST_C = RRW'(num_vcs - 1);

  logic [cnt_width-1:0] cnt_q [num_vcs];
  logic [cnt_width-1:0] cnt_d [num_vcs];
  logic [cnt_width-1:0] shared_used_q;
  logic [cnt_width-1:0] shared_used_d;
  logic [cnt_width-1:0] wr_cnt;

  logic [RRW-1:0] rr_q;
  logic [RRW-1:0] rr_d;
  logic [RRW-1:0] gnt_idx;
  logic [RRW:0]   scan;

  logic [num_vcs-1:0] empty;
  logic [num_vcs-1:0] eligible;
  logic [num_vcs-1:0] gnt;
  logic [num_vcs-1:0] wr_v;
  logic               found;
  logic               sh_inc;
  logic               sh_dec;

  logic               credit_valid_q;
  logic [num_vcs-1:0] credit_vc_q;

  // A malformed in_vc must never be admitted, even if its OR'd count looks free.
  always_comb begin
    wr_cnt = '0;
    for (int v = 0; v < num_vcs; v++) begin
      if (in_vc[v]) wr_cnt = wr_cnt | cnt_q[v];
    end
    in_accept = in_valid & $onehot(in_vc) & ~bank_full &
                ((wr_cnt < RES_C) | (shared_used_q < SHR_C));
  end

  assign write_enable    = in_accept;
  assign vc_written_into = in_vc;
  assign wr_v            = in_vc & {num_vcs{in_accept}};

  always_comb begin
    empty = '0;
    for (int v = 0; v < num_vcs; v++) begin
      empty[v] = (cnt_q[v] == '0);
    end
  end

  assign vc_empty = empty;
  assign eligible = rd_req & ~empty;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    scan    = '0;
    for (int i = 0; i < num_vcs; i++) begin
      scan = {1'b0, rr_q} + (RRW + 1)'(i);
      if (scan >= NV_C) scan = scan - NV_C;
      if (!found && eligible[scan[RRW-1:0]]) begin
        found              = 1'b1;
        gnt[scan[RRW-1:0]] = 1'b1;
        gnt_idx            = scan[RRW-1:0];
      end
    end
  end

  assign read_enable  = found;
  assign vc_read_from = gnt;
  assign rd_grant     = gnt;

  always_comb begin
    rr_d = rr_q;
    if (found) rr_d = (gnt_idx == LAST_C) ? '0 : gnt_idx + 1'b1;
  end

  // At most one VC is written and one read per cycle, so shared_used moves by -1..+1.
  always_comb begin
    sh_inc = 1'b0;
    sh_dec = 1'b0;
    for (int v = 0; v < num_vcs; v++) begin
      cnt_d[v] = cnt_q[v];
      if (wr_v[v] && !gnt[v]) begin
        cnt_d[v] = cnt_q[v] + 1'b1;
        if (cnt_q[v] >= RES_C) sh_inc = 1'b1;
      end else if (gnt[v] && !wr_v[v]) begin
        cnt_d[v] = cnt_q[v] - 1'b1;
        if (cnt_q[v] > RES_C) sh_dec = 1'b1;
      end
    end
    shared_used_d = shared_used_q + cnt_width'(sh_inc) - cnt_width'(sh_dec);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < num_vcs; v++) cnt_q[v] <= '0;
      shared_used_q  <= '0;
      rr_q           <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
    end else begin
      for (int v = 0; v < num_vcs; v++) cnt_q[v] <= cnt_d[v];
      shared_used_q  <= shared_used_d;
      rr_q           <= rr_d;
      credit_valid_q <= found;
      credit_vc_q    <= gnt;
    end
  end

  assign credit_valid = credit_valid_q;
  assign credit_vc    = credit_vc_q;

`ifdef DYNVC_OVERFLOW_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (in_valid && !in_accept) begin
      err_q <= 1'b1;
    end
  end

  assign error_overflow = err_q;
`else
  assign error_overflow = 1'b0;
`endif

  for (genvar g = 0; g < num_vcs; g++) begin : g_chk
    a_cnt_max: assert property (
      @(posedge clk) disable iff (!reset) cnt_q[g] <= DEP_C);
    a_no_underflow: assert property (
      @(posedge clk) disable iff (!reset) !(gnt[g] && cnt_q[g] == '0));
  end

  a_shared_max: assert property (
    @(posedge clk) disable iff (!reset) shared_used_q <= SHR_C);

endmodule

// File: doc/dynvc_buffer_ctrl.md
Name: dynvc_buffer_ctrl

Overview:
Per-input-port control stage that sits directly in front of the shared dynamic-VC memory bank. It decides whether an arriving flit may be written, generating write_enable and vc_written_into. It tracks per-VC occupancy with a reserved-plus-shared allocation policy and arbitrates switch read requests into read_enable and vc_read_from. It also returns one credit upstream per flit drained. It carries no flit data; it drives only the memory bank's control pins.

Parameters:
num_vcs, 10, number of virtual channels sharing the bank
buffer_depth, 32, total flit slots in the bank
reserved_per_vc, 1, slots guaranteed to each VC; must satisfy num_vcs*reserved_per_vc <= buffer_depth
cnt_width (localparam), clogb(buffer_depth+1), width of occupancy counters

Ports:
clk  in  1  clock
reset  in  1  reset
in_valid  in  1  flit arriving from channel this cycle
in_vc  in  num_vcs  one-hot VC of arriving flit
in_accept  out  1  arriving flit is written this cycle
write_enable  out  1  to memory bank write_enable
vc_written_into  out  num_vcs  to memory bank; equals in_vc
rd_req  in  num_vcs  multi-hot read requests from switch allocator
read_enable  out  1  to memory bank read_enable
vc_read_from  out  num_vcs  one-hot granted VC, to memory bank
rd_grant  out  num_vcs  equals vc_read_from when read_enable, else 0
bank_full  in  1  memory_bank_full from bank
credit_valid  out  1  credit returned upstream
credit_vc  out  num_vcs  one-hot VC of returned credit
vc_empty  out  num_vcs  per-VC count==0
error_overflow  out  1  see Optional Feature

Behaviour:
- Reset is asynchronous and active-low. Clock is clk. On reset: all VC counters 0, shared_used 0, rr pointer at VC0, credit_valid 0, credit_vc 0, error_overflow 0, vc_empty all 1.
- shared_size = buffer_depth - num_vcs*reserved_per_vc.
- shared_used is a register equal to the sum over VCs of max(count_v - reserved_per_vc, 0).
- Write admission is combinational. in_accept = in_valid & ~bank_full & (count_v < reserved_per_vc | shared_used < shared_size).
- write_enable = in_accept. vc_written_into = in_vc, always.
- Read arbitration uses eligible = rd_req & ~vc_empty and a round-robin pick starting at the rr pointer. Both are combinational.
- read_enable = |eligible. After a grant, the rr pointer advances to the granted VC + 1, wrapping num_vcs-1 -> 0.
- A VC written at cycle t becomes eligible at t+1, because vc_empty is derived from registered counts. A read is never granted in the same cycle as the first write to an empty VC.
- Counter update per clock:
  - write only: count +1; shared_used +1 if the old count >= reserved_per_vc.
  - read only: count -1; shared_used -1 if the old count > reserved_per_vc.
  - write and read on the same VC: both unchanged.
  - write and read on different VCs: each updated independently, with a net shared_used change.
- Credits are registered, 1 cycle latency. credit_valid(t+1) = read_enable(t); credit_vc(t+1) = vc_read_from(t).
- Counters saturate: never above buffer_depth, never below 0. Guaranteed by construction; checked by assertions.
- Malformed in_vc (not one-hot) with in_valid is treated as not accepted.

Optional Feature:
DYNVC_OVERFLOW_CHECK_EN
- Defined: error_overflow is sticky and set the cycle after in_valid=1 & in_accept=0, i.e. an upstream credit violation. Cleared only by reset.
- Not defined: error_overflow is tied 0, and refused flits are silently dropped.
- Admission logic is identical in both builds.

Test Plan:
- num_vcs=4, depth=8, reserved=1 (shared_size=4). Write 5 flits to VC0 -> all accepted, count0=5, shared_used=4. A 6th write to VC0 is refused; a write to VC1 is accepted.
- Fill bank with 8 flits (VC0=5, VC1..3=1), assert bank_full, then present a write -> in_accept=0. With the macro defined, error_overflow=1 next cycle.
- rd_req=4'b1111 with all VCs non-empty for 4 cycles -> grants VC0,VC1,VC2,VC3 in order; credit_vc lags grants by exactly 1 cycle.
- Write and read VC2 (count 3) in the same cycle -> count stays 3, shared_used unchanged, credit_valid=1 next cycle.
- First write to empty VC3 at cycle t with rd_req[3]=1 -> no grant at t, grant at t+1.
- Assert reset mid-traffic with counts nonzero -> all counts 0, vc_empty=4'b1111, credit_valid=0, and read_enable=0 immediately (asynchronous).
